pll_reconfig_seq: RTL
=====================

Name: pll_reconfig_seq

Overview:
- Sequencer that drives the Avalon-MM management port of the ram-clock PLL reconfiguration core (pll_cfg), directly upstream of it.
- On a start request it captures one M/K/C0 parameter triple and writes the fixed 8-register reconfiguration sequence.
- It then pulses the PLL reset, waits for lock, and reports completion or a lock timeout.
- It lets the top-level frequency stepping/auto-sweep logic request a new clock with a single pulse.

Parameters:
- GAP_CYCLES, 8, idle cycles from one accepted write to the next write request (minimum 1).
- RST_CYCLES, 8, width of the pll_reset pulse in clk cycles (minimum 1).
- LOCK_TIMEOUT, 1000000, maximum clk cycles to wait for synchronized lock after pll_reset deasserts.

Ports:
- clk  in  1  management clock (50 MHz domain)
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; captures cfg_m/cfg_k/cfg_c0
- cfg_m  in  32  M counter word (register 4)
- cfg_k  in  32  fractional K word (register 7)
- cfg_c0  in  32  C0 counter word (register 5)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sequence end
- timeout_err  out  1  sticky; lock not seen within LOCK_TIMEOUT
- mgmt_address  out  6  management register address
- mgmt_writedata  out  32  management write data
- mgmt_write  out  1  write request
- mgmt_waitrequest  in  1  management stall
- pll_reset  out  1  PLL reset
- locked  in  1  PLL lock, asynchronous; 2-flop synchronized internally to locked_s

Behaviour:
- Reset values: busy=0, done=0, timeout_err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, pll_reset=0. State is IDLE; pending=0; all counters 0. Reset is effective mid-sequence, including mid-handshake; mgmt_write drops immediately.
- States: IDLE, WRITE, GAP, PRST, WAIT_LOCK.
- Write table, index 0..7, as (address, data): (0, 0), (4, cfg_m), (7, cfg_k), (3, 0x10000), (5, cfg_c0), (9, 1), (8, 7), (2, 0). Data comes from the captured registers, never live inputs.
- IDLE + start: capture cfg words, clear timeout_err, idx=0, go to WRITE. busy=1 from the next cycle.
- WRITE: present mgmt_write=1 with the table entry. Address and data are held stable while mgmt_waitrequest=1. The write is accepted in the cycle with mgmt_write=1 and mgmt_waitrequest=0. The next cycle mgmt_write=0 and the state goes to GAP.
- GAP: count GAP_CYCLES-1 further idle cycles, so accepted writes are at least GAP_CYCLES apart.
  - If idx<7: idx+1, go to WRITE.
  - If idx==7: go to PRST.
- PRST: pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with the timeout counter at 0.
- WAIT_LOCK: count cycles.
  - locked_s=1: done pulse, go to IDLE.
  - Counter reaches LOCK_TIMEOUT first: timeout_err=1, done pulse, go to IDLE.
  - locked_s is ignored during PRST.
- busy drops in the same cycle done is asserted.
- start while busy: set pending and re-capture cfg words; the last start wins.
  - pending is acted on at the next GAP, PRST or WAIT_LOCK cycle, never inside WRITE. This guarantees an in-flight handshake always completes.
  - Action: idx=0, pll_reset=0, clear pending and timeout_err, go to WRITE.
  - No done pulse is emitted for the aborted sequence.
- start in the same cycle as done: treated as IDLE+start in the next cycle; the start is not lost.
- Counters are sized with $clog2(parameter+1) and saturate, never wrap.

Test Plan:
- Reset, start with cfg_m=0x00404, cfg_k=0xB33332DD, cfg_c0=0x20201, waitrequest=0, locked rises 20 cycles after pll_reset falls -> 8 writes in table order, each exactly 8 cycles apart; pll_reset high 8 cycles; done pulse once; timeout_err=0.
- waitrequest held high 5 cycles on the write to address 7 -> mgmt_write/address/data stable all 6 cycles, exactly one acceptance, sequence continues normally.
- locked never rises, LOCK_TIMEOUT=100 -> done pulse 100 cycles after pll_reset falls, timeout_err=1 and held; next start clears it.
- Second start (cfg_m=0x167) during the write to address 5 under waitrequest stall -> that write completes, then the restart writes address 0 and then address 4 with data 0x167; exactly one done pulse total.
- Assert reset during PRST -> pll_reset, busy and mgmt_write drop asynchronously; the next start runs the full sequence from index 0.
- Toggle locked glitchily during PRST -> ignored; done only after locked_s is seen in WAIT_LOCK.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: writes the fixed 8-entry M/K/C0 reconfiguration table to the
// PLL reconfiguration core's management port. It then pulses pll_reset and waits
// for the synchronized lock indication, reporting done or a sticky lock timeout.
module pll_reconfig_seq #(
    parameter int GAP_CYCLES   = 8,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [31:0] cfg_c0,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    output logic        pll_reset,
    input  logic        locked
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

    // Register addresses of the reconfiguration sequence, in write order.
    localparam logic [5:0] TBL_ADDR [8] = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
    // Constant data words; entries 1, 2 and 4 are replaced by the captured M/K/C0.
    localparam logic [31:0] TBL_CONST [8] = '{32'h0, 32'h0, 32'h0, 32'h0001_0000,
                                              32'h0, 32'h1, 32'h7, 32'h0};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        GAP       = 3'd2,
        PRST      = 3'd3,
        WAIT_LOCK = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         idx_reg, idx_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [RST_W-1:0]   rst_cnt_reg, rst_cnt_next;
    logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic               pending_reg, pending_next;
    logic               terr_reg, terr_next;
    logic               done_reg, done_next;
    logic [5:0]         addr_reg, addr_next;
    logic [31:0]        data_reg, data_next;
    logic [31:0]        cap_m_reg, cap_k_reg, cap_c0_reg;
    logic [1:0]         lock_sync_reg;
    logic               locked_s;
    logic               restart;
    logic [31:0]        tbl_data [8];

    assign locked_s = lock_sync_reg[1];

    // Table data: variable entries come from the captured words, never live inputs.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tbl
            if (gi == 1) begin : g_m
                assign tbl_data[gi] = cap_m_reg;
            end else if (gi == 2) begin : g_k
                assign tbl_data[gi] = cap_k_reg;
            end else if (gi == 4) begin : g_c0
                assign tbl_data[gi] = cap_c0_reg;
            end else begin : g_const
                assign tbl_data[gi] = TBL_CONST[gi];
            end
        end
    endgenerate

    // Next-state logic: table walk, reset pulse, lock wait and restart handling.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        gap_cnt_next = gap_cnt_reg;
        rst_cnt_next = rst_cnt_reg;
        tmo_cnt_next = tmo_cnt_reg;
        terr_next    = terr_reg;
        done_next    = 1'b0;
        restart      = 1'b0;
        addr_next    = addr_reg;
        data_next    = data_reg;
        // A start while a sequence is running is remembered until a safe point.
        pending_next = pending_reg | (start && (state_reg != IDLE));

        case (state_reg)
            IDLE: begin
                if (start || pending_reg) begin
                    restart = 1'b1;
                end
            end
            WRITE: begin
                // Pending restarts are never taken here so the handshake completes.
                if (!mgmt_waitrequest) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                end
            end
            GAP: begin
                if (pending_reg) begin
                    restart = 1'b1;
                end else if (int'(gap_cnt_reg) + 2 >= GAP_CYCLES) begin
                    if (idx_reg == 3'd7) begin
                        state_next   = PRST;
                        rst_cnt_next = '0;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = WRITE;
                    end
                end else begin
                    gap_cnt_next = (gap_cnt_reg == '1) ? gap_cnt_reg : gap_cnt_reg + 1'b1;
                end
            end
            PRST: begin
                if (pending_reg) begin
                    restart = 1'b1;
                end else if (int'(rst_cnt_reg) + 1 >= RST_CYCLES) begin
                    state_next   = WAIT_LOCK;
                    tmo_cnt_next = '0;
                end else begin
                    rst_cnt_next = (rst_cnt_reg == '1) ? rst_cnt_reg : rst_cnt_reg + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (pending_reg) begin
                    restart = 1'b1;
                end else if (locked_s) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (int'(tmo_cnt_reg) + 1 >= LOCK_TIMEOUT) begin
                    terr_next  = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = (tmo_cnt_reg == '1) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (restart) begin
            state_next   = WRITE;
            idx_next     = 3'd0;
            pending_next = 1'b0;
            terr_next    = 1'b0;
        end

        // Address/data are latched on entry to WRITE so they stay put during stalls.
        if ((state_next == WRITE) && (state_reg != WRITE)) begin
            addr_next = TBL_ADDR[idx_next];
            data_next = tbl_data[idx_next];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            gap_cnt_reg <= '0;
            rst_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            pending_reg <= 1'b0;
            terr_reg    <= 1'b0;
            done_reg    <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            gap_cnt_reg <= gap_cnt_next;
            rst_cnt_reg <= rst_cnt_next;
            tmo_cnt_reg <= tmo_cnt_next;
            pending_reg <= pending_next;
            terr_reg    <= terr_next;
            done_reg    <= done_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
        end
    end

    // Capture the parameter triple on every start; the most recent start wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_m_reg  <= '0;
            cap_k_reg  <= '0;
            cap_c0_reg <= '0;
        end else if (start) begin
            cap_m_reg  <= cfg_m;
            cap_k_reg  <= cfg_k;
            cap_c0_reg <= cfg_c0;
        end
    end

    // Two-flop synchronizer for the asynchronous PLL lock signal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_sync_reg <= '0;
        end else begin
            lock_sync_reg <= {lock_sync_reg[0], locked};
        end
    end

    assign busy           = (state_reg != IDLE);
    assign done           = done_reg;
    assign timeout_err    = terr_reg;
    assign mgmt_write     = (state_reg == WRITE);
    assign mgmt_address   = addr_reg;
    assign mgmt_writedata = data_reg;
    assign pll_reset      = (state_reg == PRST);

endmodule
